sub_bytes2: RTL and testbench



---
 rtl/sub_bytes2_pkg.sv | 36 +++
 rtl/sub_bytes2_sbox.sv | 12 +
 rtl/sub_bytes2.sv | 44 ++++
 tb/tb_sub_bytes2.sv | 131 +++++++++++++
 4 files changed

// File: rtl/sub_bytes2_pkg.sv
// Shared types and the AES forward S-box table for the sub_bytes2 SubBytes stage.
// The SUB_BYTES2_COMB_EN build option is handled in the top module, not here.
package sub_bytes2_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;

    typedef logic [AES_STATE_W-1:0] aes_state_t;

    // Entry 0 sits in the most significant byte so the table reads in natural order.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [AES_BYTE_W-1:0] sbox_fwd(input logic [AES_BYTE_W-1:0] val);
        int idx;
        idx = 255 - int'(val);
        return SBOX_TBL[idx*AES_BYTE_W +: AES_BYTE_W];
    endfunction

endpackage

// File: rtl/sub_bytes2_sbox.sv
// Single-byte AES forward S-box lookup, purely combinational.
// Unaffected by SUB_BYTES2_COMB_EN.
module sub_bytes2_sbox
    import sub_bytes2_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] byte_in,
    output logic [AES_BYTE_W-1:0] byte_out
);

    assign byte_out = sbox_fwd(byte_in);

endmodule

// File: rtl/sub_bytes2.sv
// AES SubBytes: 16 parallel S-box lookups with a registered output (1-cycle latency).
// Define SUB_BYTES2_COMB_EN for a zero-latency combinational build; Clk/Rst are then unused.
module sub_bytes2
    import sub_bytes2_pkg::*;
#(
    parameter int WORD = 32,
    parameter int ZERO = 0,
    parameter int Nb   = 128
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [ZERO+Nb-1:ZERO]  state_in,
    output logic [ZERO+Nb-1:ZERO]  state_out
);

    logic [ZERO+Nb-1:ZERO] sub;

    // Walk the state word by word, byte by byte; byte k covers bits [8k+7:8k] above ZERO.
    for (genvar w = 0; w < Nb / WORD; w++) begin : g_word
        for (genvar b = 0; b < WORD / AES_BYTE_W; b++) begin : g_byte
            localparam int K = w * (WORD / AES_BYTE_W) + b;
            sub_bytes2_sbox u_sbox (
                .byte_in  (state_in[ZERO + K*AES_BYTE_W +: AES_BYTE_W]),
                .byte_out (sub[ZERO + K*AES_BYTE_W +: AES_BYTE_W])
            );
        end
    end

`ifdef SUB_BYTES2_COMB_EN
    logic unused_clk_rst;
    assign unused_clk_rst = Clk ^ Rst;
    assign state_out = sub;
`else
    // Reset loads all-zero, deliberately not SBOX(0).
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_out <= '0;
        end else begin
            state_out <= sub;
        end
    end
`endif

endmodule

// File: tb/tb_sub_bytes2.sv
// Self-checking bench for sub_bytes2; reference S-box derived from GF(2^8) inverse + affine map.
// Honours SUB_BYTES2_COMB_EN (zero latency, reset checks skipped).
module tb_sub_bytes2;

    logic         Clk = 1'b0;
    logic         Rst;
    logic [127:0] state_in;
    logic [127:0] state_out;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] ref_sbox [256];

    sub_bytes2 dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .state_in  (state_in),
        .state_out (state_out)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_sbox[s[8*k +: 8]];
        return r;
    endfunction

    task automatic build_model();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (v != 0 && gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
            ref_sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic check(input string tag, input logic [127:0] exp);
        vectors++;
        assert (state_out === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, state_out, exp);
        end
    endtask

    // Drive an input and wait out the build's latency before sampling.
    task automatic apply(input logic [127:0] din);
        state_in = din;
`ifdef SUB_BYTES2_COMB_EN
        #1;
`else
        @(posedge Clk);
        #1;
`endif
    endtask

    initial begin
        logic [127:0] rnd;
        logic [7:0]   v;
        build_model();
        Rst      = 1'b1;
        state_in = 128'h0;

`ifndef SUB_BYTES2_COMB_EN
        @(posedge Clk); #1;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge Clk); #1;
        check("reset_hold", 128'h0);
`endif
        Rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            apply({16{v}});
            check($sformatf("byte_%02h", v), {16{ref_sbox[v]}});
        end

        apply(128'h89d810e8855ace682d1843d8cb128fe4);
        check("vec1", 128'ha761ca9b97be8b45d8ad1a611fc97369);
        apply(128'h4915598f55e5d7a0daca94fa1f0a63f7);
        check("vec2", 128'h3b59cb73fcd90ee05774222dc067fb68);
        apply(128'hfa636a2825b339c940668a3157244d17);
        check("vec3", 128'h2dfb02343f6d12dd09337ec75b36e3f0);

        apply(128'h247240236966b3fa6ed2753288425b6c);
        check("stream_a", 128'h36400926f9336d2d9fb59d23c42c3950);
        apply(128'hc81677bc9b7ac93b25027992b0261996);
        check("stream_b", 128'he847f56514dadde23f77b64fe7f7d490);

        for (int i = 0; i < 200; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            apply(rnd);
            check($sformatf("rand_%0d", i), ref_sub(rnd));
        end

`ifndef SUB_BYTES2_COMB_EN
        apply(128'h00112233445566778899aabbccddeeff);
        check("pre_midreset", ref_sub(128'h00112233445566778899aabbccddeeff));
        Rst = 1'b1;
        apply({$urandom, $urandom, $urandom, $urandom});
        check("midstream_reset", 128'h0);
        Rst = 1'b0;
        apply(128'h0);
        check("post_reset_zero", {16{8'h63}});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
